lsu_axi_ctrl: RTL and testbench

// Load/store unit stage feeding the MEM/WB pipeline register. Accepts one load or store per transaction from EX/MEM.

---
 rtl/lsu_pkg.sv | 13 +
 rtl/lsu_align.sv | 29 ++
 rtl/lsu_axi_ctrl.sv | 129 ++++++++++++
 tb/tb_lsu_axi_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size codes, bus response codes, FSM encoding and strobe mask helper for the LSU
package lsu_pkg;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WREQ, S_WRESP} state_e;
   // funct3[1:0] carries the access size; funct3=111 falls into the doubleword mask
   function automatic logic [7:0] size_mask(input logic [2:0] funct3);
      return funct3[1:0] == SZ_B ? 8'h01 : funct3[1:0] == SZ_H ? 8'h03 : funct3[1:0] == SZ_W ? 8'h0F : 8'hFF;
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane selection, load extension, store lane placement and alignment check
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  addr_i,
   input  logic [2:0]  funct3_i,
   input  logic [63:0] rdata_i,
   input  logic [63:0] wdata_i,
   output logic [63:0] ext_rdata_o,
   output logic [63:0] lane_wdata_o,
   output logic [7:0]  strb_o,
   output logic        misalign_o
);
   logic [63:0] sh;
   logic        sx;
   // funct3[2] selects zero extension; the lane is brought down to bit 0 before extending
   always_comb begin
      sh = rdata_i >> {addr_i, 3'b000};
      sx = !funct3_i[2];
      ext_rdata_o = funct3_i[1:0] == SZ_B ? {{56{sx & sh[7]}}, sh[7:0]}
                  : funct3_i[1:0] == SZ_H ? {{48{sx & sh[15]}}, sh[15:0]}
                  : funct3_i[1:0] == SZ_W ? {{32{sx & sh[31]}}, sh[31:0]} : sh;
      lane_wdata_o = wdata_i << {addr_i, 3'b000};
      strb_o = size_mask(funct3_i) << addr_i;
      misalign_o = funct3_i[1:0] == SZ_H ? addr_i[0]
                 : funct3_i[1:0] == SZ_W ? |addr_i[1:0]
                 : funct3_i[1:0] == SZ_D ? |addr_i : 1'b0;
   end
endmodule

// File: rtl/lsu_axi_ctrl.sv
// lsu_axi_ctrl: MEM-stage load/store unit driving a 64-bit AXI-lite master port
module lsu_axi_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_load,
   input  logic              in_store,
   input  logic [2:0]        in_funct3,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   output logic              mem_idle,
   output logic              lsu_r_ready,
   output logic              lsu_r_valid,
   output logic              lsu_w_valid,
   output logic              lsu_w_ready,
   output logic [DATA_W-1:0] lsu_r_data,
   output logic              lsu_err,
   output logic              ar_valid,
   input  logic              ar_ready,
   output logic [ADDR_W-1:0] ar_addr,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [DATA_W-1:0] r_data,
   input  logic [1:0]        r_resp,
   output logic              aw_valid,
   input  logic              aw_ready,
   output logic [ADDR_W-1:0] aw_addr,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [DATA_W-1:0] w_data,
   output logic [DATA_W/8-1:0] w_strb,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [1:0]        b_resp
);
   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [2:0]          f3_q;
   logic [DATA_W-1:0]   wdata_q, r_data_q, ext;
   logic                aw_done_q, w_done_q, r_valid_q, w_ready_q, err_q;
   logic                accept, misalign;
   logic [2:0]          sel_addr, sel_f3;

   assign accept = state_q == S_IDLE && in_valid && (in_load || in_store);
   // in IDLE the live request is checked for alignment; afterwards the captured copy drives the lanes
   assign sel_addr = state_q == S_IDLE ? in_addr[2:0] : addr_q[2:0];
   assign sel_f3 = state_q == S_IDLE ? in_funct3 : f3_q;
   assign lsu_r_valid = r_valid_q;
   assign lsu_w_ready = w_ready_q;
   assign lsu_err = err_q;
   assign lsu_r_data = r_data_q;

   lsu_align u_align (
      .addr_i      (sel_addr),
      .funct3_i    (sel_f3),
      .rdata_i     (r_data),
      .wdata_i     (wdata_q),
      .ext_rdata_o (ext),
      .lane_wdata_o(w_data),
      .strb_o      (w_strb),
      .misalign_o  (misalign)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else state_q <= state_d;
   end

   // next state: misaligned requests never leave IDLE; WREQ waits for both sticky handshakes
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = accept && !misalign ? (in_load ? S_RADDR : S_WREQ) : S_IDLE;
         S_RADDR: state_d = ar_ready ? S_RDATA : S_RADDR;
         S_RDATA: state_d = r_valid ? S_IDLE : S_RDATA;
         S_WREQ:  state_d = (aw_done_q || aw_ready) && (w_done_q || w_ready) ? S_WRESP : S_WREQ;
         S_WRESP: state_d = b_valid ? S_IDLE : S_WRESP;
         default: state_d = S_IDLE;
      endcase
   end

   // bus channel controls and issue pulses decoded from the current state
   always_comb begin
      mem_idle = state_q == S_IDLE;
      lsu_r_ready = accept && in_load && !misalign;
      lsu_w_valid = accept && !in_load && !misalign;
      ar_valid = state_q == S_RADDR;
      r_ready = state_q == S_RDATA;
      aw_valid = state_q == S_WREQ && !aw_done_q;
      w_valid = state_q == S_WREQ && !w_done_q;
      b_ready = state_q == S_WRESP;
      ar_addr = {addr_q[ADDR_W-1:3], 3'b000};
      aw_addr = {addr_q[ADDR_W-1:3], 3'b000};
   end

   // request capture, sticky write handshakes, load result and completion/error pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         f3_q <= '0;
         wdata_q <= '0;
         r_data_q <= '0;
         aw_done_q <= 1'b0;
         w_done_q <= 1'b0;
         r_valid_q <= 1'b0;
         w_ready_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         if (accept) begin
            addr_q <= in_addr;
            f3_q <= in_funct3;
            wdata_q <= in_wdata;
         end
         if (r_ready && r_valid) r_data_q <= ext;
         aw_done_q <= state_q == S_WREQ && (aw_done_q || aw_ready);
         w_done_q <= state_q == S_WREQ && (w_done_q || w_ready);
         r_valid_q <= (accept && misalign && in_load) || (r_ready && r_valid);
         w_ready_q <= (accept && misalign && !in_load) || (b_ready && b_valid);
         err_q <= (accept && misalign) || (r_ready && r_valid && r_resp != RESP_OKAY)
                  || (b_ready && b_valid && b_resp != RESP_OKAY);
      end
   end
endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// tb_lsu_axi_ctrl: table-driven directed checks of the LSU bus controller
module tb_lsu_axi_ctrl;
   logic        clk, rst;
   logic        in_valid, in_load, in_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr;
   logic [63:0] in_wdata;
   logic        mem_idle, lsu_r_ready, lsu_r_valid, lsu_w_valid, lsu_w_ready, lsu_err;
   logic [63:0] lsu_r_data;
   logic        ar_valid, ar_ready, r_valid, r_ready, aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
   logic [31:0] ar_addr, aw_addr;
   logic [63:0] r_data, w_data;
   logic [1:0]  r_resp, b_resp;
   logic [7:0]  w_strb;

   int n_cmp = 0;
   int n_fail = 0;

   localparam logic [63:0] D1 = 64'h1122334455667788;
   localparam logic [63:0] D2 = 64'h1122803344556677;
   localparam logic [63:0] D3 = 64'hCAFEBABE87654321;

   typedef struct {
      string       name;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] bus;
      logic [1:0]  resp;
      int          ar_dly, aw_dly, w_dly;
      logic [63:0] exp_data;
      logic [7:0]  exp_strb;
      logic        exp_err, exp_mis;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   lsu_axi_ctrl #(.ADDR_W(32), .DATA_W(64)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3),
      .in_addr(in_addr), .in_wdata(in_wdata),
      .mem_idle(mem_idle), .lsu_r_ready(lsu_r_ready), .lsu_r_valid(lsu_r_valid),
      .lsu_w_valid(lsu_w_valid), .lsu_w_ready(lsu_w_ready), .lsu_r_data(lsu_r_data), .lsu_err(lsu_err),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
      .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void add(input string nm, input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [63:0] wd, input logic [63:0] bus, input logic [1:0] resp,
                               input int ard, input int awd, input int wdl, input logic [63:0] ed,
                               input logic [7:0] es, input logic ee, input logic em, input int el);
      vec_t v;
      v.name = nm; v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.bus = bus; v.resp = resp;
      v.ar_dly = ard; v.aw_dly = awd; v.w_dly = wdl;
      v.exp_data = ed; v.exp_strb = es; v.exp_err = ee; v.exp_mis = em; v.exp_lat = el;
      vecs.push_back(v);
   endfunction

   task automatic run_vec(input vec_t v);
      int lat, n_cpl, n_ar, n_aw, n_w;
      logic err_at, low, acc;
      logic [63:0] wd;
      logic [7:0] sb;
      logic [31:0] ar_a, aw_a;
      lat = 0; n_cpl = 0; n_ar = 0; n_aw = 0; n_w = 0;
      err_at = 1'b0; low = 1'b0; wd = '0; sb = '0; ar_a = '0; aw_a = '0;
      @(negedge clk);
      in_valid = 1'b1; in_load = !v.st; in_store = v.st; in_funct3 = v.f3; in_addr = v.addr; in_wdata = v.wdata;
      r_data = v.bus; r_resp = v.resp; b_resp = v.resp; r_valid = 1'b1; b_valid = 1'b1;
      ar_ready = v.ar_dly == 0; aw_ready = v.aw_dly == 0; w_ready = v.w_dly == 0;
      #1;
      chk({v.name, " mem_idle at accept"}, mem_idle, 1);
      acc = v.st ? lsu_w_valid : lsu_r_ready;
      chk({v.name, " issue pulse"}, acc, !v.exp_mis);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         in_valid = 1'b0; in_load = v.st; in_store = !v.st; in_funct3 = 3'b011;
         in_addr = 32'h0000_0001; in_wdata = '1;
         ar_ready = i > v.ar_dly; aw_ready = i > v.aw_dly; w_ready = i > v.w_dly;
         #1;
         if (ar_valid && ar_ready) begin n_ar++; ar_a = ar_addr; end
         if (aw_valid && aw_ready) begin n_aw++; aw_a = aw_addr; end
         if (w_valid && w_ready) begin n_w++; wd = w_data; sb = w_strb; end
         if (lat == 0 && !mem_idle) low = 1'b1;
         if (lsu_r_valid || lsu_w_ready) begin
            n_cpl++;
            if (lat == 0) begin lat = i; err_at = lsu_err; end
         end
      end
      chk({v.name, " latency"}, lat, v.exp_lat);
      chk({v.name, " completion pulses"}, n_cpl, 1);
      chk({v.name, " err"}, err_at, v.exp_err);
      chk({v.name, " mem_idle dropped"}, low, !v.exp_mis);
      chk({v.name, " ar handshakes"}, n_ar, !v.st && !v.exp_mis);
      chk({v.name, " aw handshakes"}, n_aw, v.st && !v.exp_mis);
      chk({v.name, " w handshakes"}, n_w, v.st && !v.exp_mis);
      if (n_ar == 1) chk({v.name, " ar_addr"}, ar_a, {v.addr[31:3], 3'b000});
      if (n_aw == 1) chk({v.name, " aw_addr"}, aw_a, {v.addr[31:3], 3'b000});
      if (!v.st) chk({v.name, " lsu_r_data"}, lsu_r_data, v.exp_data);
      if (v.st && !v.exp_mis) begin
         chk({v.name, " w_data"}, wd, v.exp_data);
         chk({v.name, " w_strb"}, sb, v.exp_strb);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_funct3 = '0; in_addr = '0; in_wdata = '0;
      ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0; aw_ready = 1'b0; w_ready = 1'b0;
      b_valid = 1'b0; b_resp = '0;
      //      name       st f3    addr          wdata                  bus resp   ar aw w  exp_data               strb  err mis lat
      add("LD",        0, 3'd3, 32'h80000008, 64'h0,                 D1, 2'b00, 0, 0, 0, D1,                    8'h00, 0, 0, 3);
      add("LB",        0, 3'd0, 32'h80000005, 64'h0,                 D2, 2'b00, 0, 0, 0, 64'hFFFFFFFFFFFFFF80, 8'h00, 0, 0, 3);
      add("LBU",       0, 3'd4, 32'h80000005, 64'h0,                 D2, 2'b00, 0, 0, 0, 64'h80,                8'h00, 0, 0, 3);
      add("LHU",       0, 3'd5, 32'h80000006, 64'h0,                 D2, 2'b00, 0, 0, 0, 64'h1122,              8'h00, 0, 0, 3);
      add("LH",        0, 3'd1, 32'h80000002, 64'h0,                 D3, 2'b00, 0, 0, 0, 64'hFFFFFFFFFFFF8765, 8'h00, 0, 0, 3);
      add("LW",        0, 3'd2, 32'h80000004, 64'h0,                 D3, 2'b00, 0, 0, 0, 64'hFFFFFFFFCAFEBABE, 8'h00, 0, 0, 3);
      add("LWU",       0, 3'd6, 32'h80000004, 64'h0,                 D3, 2'b00, 0, 0, 0, 64'h00000000CAFEBABE, 8'h00, 0, 0, 3);
      add("F3_111",    0, 3'd7, 32'h80000010, 64'h0,                 D3, 2'b00, 1, 0, 0, D3,                    8'h00, 0, 0, 4);
      add("LW_mis",    0, 3'd2, 32'h80000002, 64'h0,                 D1, 2'b00, 0, 0, 0, D3,                    8'h00, 1, 1, 1);
      add("LD_slverr", 0, 3'd3, 32'h80000000, 64'h0,                 D1, 2'b10, 0, 0, 0, D1,                    8'h00, 1, 0, 3);
      add("SW_awdly",  1, 3'd2, 32'h80000004, 64'h12345678DEADBEEF, D1, 2'b00, 0, 2, 0, 64'hDEADBEEF00000000, 8'hF0, 0, 0, 5);
      add("SB",        1, 3'd0, 32'h80000003, 64'hAB,                D1, 2'b00, 0, 0, 0, 64'h00000000AB000000, 8'h08, 0, 0, 3);
      add("SH",        1, 3'd1, 32'h80000006, 64'hBEEF,              D1, 2'b00, 0, 0, 0, 64'hBEEF000000000000, 8'hC0, 0, 0, 3);
      add("SD_wdly",   1, 3'd3, 32'h80000008, 64'h0123456789ABCDEF, D1, 2'b00, 0, 0, 1, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 4);
      add("SH_mis",    1, 3'd1, 32'h80000001, 64'hBEEF,              D1, 2'b00, 0, 0, 0, 64'h0,                 8'h00, 1, 1, 1);
      add("SD_decerr", 1, 3'd3, 32'h80000000, 64'h55AA55AA55AA55AA, D1, 2'b11, 0, 0, 0, 64'h55AA55AA55AA55AA, 8'hFF, 1, 0, 3);
      @(negedge clk);
      #1;
      chk("reset mem_idle", mem_idle, 1);
      chk("reset lsu_r_data", lsu_r_data, 0);
      chk("reset valids", {ar_valid, aw_valid, w_valid, r_ready, b_ready}, 0);
      chk("reset pulses", {lsu_r_ready, lsu_r_valid, lsu_w_valid, lsu_w_ready, lsu_err}, 0);
      @(negedge clk);
      rst = 1'b0;
      foreach (vecs[k]) run_vec(vecs[k]);
      @(negedge clk);
      in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_funct3 = 3'd3; in_addr = 32'h80000020;
      ar_ready = 1'b1; r_valid = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("midrst in RDATA", r_ready, 1);
      rst = 1'b1;
      #1;
      chk("midrst mem_idle", mem_idle, 1);
      chk("midrst r_ready", r_ready, 0);
      chk("midrst ar_valid", ar_valid, 0);
      chk("midrst lsu_r_data", lsu_r_data, 0);
      chk("midrst pulses", {lsu_r_valid, lsu_err, lsu_w_ready}, 0);
      r_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("postrst no completion", lsu_r_valid, 0);
      @(negedge clk);
      #1;
      chk("postrst no completion 2", lsu_r_valid, 0);
      chk("postrst mem_idle", mem_idle, 1);
      run_vec(vecs[0]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
